// File: rtl/mycpu_pkg.sv
// Shared EX-stage definitions: mul/div op encodings, divider timing constants and unit state codes.
package mycpu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MADD  = 3'd4,
    OP_MADDU = 3'd5,
    OP_MSUB  = 3'd6,
    OP_MSUBU = 3'd7
  } muldiv_op_t;

  localparam int DIV_ITERS   = 32;
  localparam int DIV_LATENCY = 34;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } md_state_t;

endpackage

// File: rtl/div_iter.sv
// Unsigned restoring divider core, one quotient bit per cycle; done rises DIV_ITERS cycles after start.
// No backpressure: start reloads the core at any time, results hold until the next start.
module div_iter
  import mycpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] dvs;
  logic [5:0]  cnt;
  logic        run;
  logic [32:0] shifted;
  logic        ge;
  logic [31:0] diff;

  // Shifted partial remainder stays below 2*divisor, so the 32-bit difference is exact when ge.
  assign shifted = {rem, quo[31]};
  assign ge      = shifted >= {1'b0, dvs};
  assign diff    = shifted[31:0] - dvs;

  always_ff @(posedge clk) begin
    if (reset) begin
      rem  <= '0;
      quo  <= '0;
      dvs  <= '0;
      cnt  <= '0;
      run  <= 1'b0;
      done <= 1'b0;
    end else if (start) begin
      rem  <= '0;
      quo  <= dividend;
      dvs  <= divisor;
      cnt  <= '0;
      run  <= 1'b1;
      done <= 1'b0;
    end else if (run) begin
      rem <= ge ? diff : shifted[31:0];
      quo <= {quo[30:0], ge};
      cnt <= cnt + 6'd1;
      if (cnt == 6'(DIV_ITERS - 1)) begin
        run  <= 1'b0;
        done <= 1'b1;
      end
    end
  end

  assign quotient  = quo;
  assign remainder = rem;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/DIV unit driving the HI/LO write bus; MUL_CYCLES (MADD +1) or 34 cycles to the write pulse.
// Busy stalls issue while in flight; flush aborts at any point. MULDIV_MADD_EN enables MADD/MSUB.
module muldiv_unit
  import mycpu_pkg::*;
#(
  parameter int MUL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi_in,
  input  logic [31:0] lo_in,
  input  logic        flush,
  output logic        busy,
  output logic        hi_write,
  output logic        lo_write,
  output logic [31:0] hi_data,
  output logic [31:0] lo_data
);

  md_state_t   state;
  muldiv_op_t  op_e;
  logic [5:0]  cnt;
  logic [63:0] res_q;
  logic        wr_q;
  logic        q_neg;
  logic        r_neg;
  logic        dvz;
  logic [31:0] a_q;

  logic        accept;
  logic        is_div;
  logic        is_madd;
  logic        sgn;
  logic signed [32:0] ma;
  logic signed [32:0] mb;
  logic signed [65:0] prod_full;
  logic [63:0] prod;
  logic [63:0] mul_res;
  logic [5:0]  mul_init;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        div_done;
  logic [31:0] div_q;
  logic [31:0] div_r;
  logic [31:0] fix_q;
  logic [31:0] fix_r;
  logic [1:0]  unused_prod_hi;

  assign op_e    = muldiv_op_t'(op);
  assign busy    = (state == S_MUL) || (state == S_DIV) || (state == S_FIX);
  assign accept  = start && !busy && !flush;
  assign is_div  = (op_e == OP_DIV) || (op_e == OP_DIVU);
  assign is_madd = op[2];
  assign sgn     = ~op[0];

  assign ma             = {sgn & a[31], a};
  assign mb             = {sgn & b[31], b};
  assign prod_full      = ma * mb;
  assign prod           = prod_full[63:0];
  assign unused_prod_hi = prod_full[65:64];

`ifdef MULDIV_MADD_EN
  localparam bit MADD_EN = 1'b1;
  // op[1] separates MSUB from MADD within the accumulate family.
  assign mul_res = !is_madd ? prod :
                   op[1]    ? ({hi_in, lo_in} - prod) : ({hi_in, lo_in} + prod);
`else
  localparam bit MADD_EN = 1'b0;
  logic unused_hilo;
  assign unused_hilo = ^{hi_in, lo_in};
  assign mul_res     = prod;
`endif

  // Counts the extra MUL-state cycles after acceptance; the accumulate adds one.
  assign mul_init = is_madd ? 6'(MUL_CYCLES) : 6'(MUL_CYCLES - 1);

  assign a_mag = (sgn && a[31]) ? (~a + 32'd1) : a;
  assign b_mag = (sgn && b[31]) ? (~b + 32'd1) : b;

  div_iter u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (accept && is_div),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  // Divide-by-zero bypasses sign correction: quotient all ones, remainder is the raw dividend.
  assign fix_q = dvz ? 32'hFFFF_FFFF : (q_neg ? (~div_q + 32'd1) : div_q);
  assign fix_r = dvz ? a_q : (r_neg ? (~div_r + 32'd1) : div_r);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      res_q   <= '0;
      wr_q    <= 1'b0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      dvz     <= 1'b0;
      a_q     <= '0;
      hi_data <= '0;
      lo_data <= '0;
    end else begin
      wr_q <= 1'b0;
      if (flush) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            state <= S_IDLE;
            if (accept) begin
              if (is_div) begin
                state <= S_DIV;
                cnt   <= '0;
                q_neg <= sgn & (a[31] ^ b[31]);
                r_neg <= sgn & a[31];
                dvz   <= (b == 32'd0);
                a_q   <= a;
              end else if (is_madd && !MADD_EN) begin
                state <= S_IDLE;
              end else if (mul_init == 6'd0) begin
                state   <= S_DONE;
                wr_q    <= 1'b1;
                hi_data <= mul_res[63:32];
                lo_data <= mul_res[31:0];
              end else begin
                state <= S_MUL;
                cnt   <= mul_init - 6'd1;
                res_q <= mul_res;
              end
            end
          end
          S_MUL: begin
            if (cnt == 6'd0) begin
              state   <= S_DONE;
              wr_q    <= 1'b1;
              hi_data <= res_q[63:32];
              lo_data <= res_q[31:0];
            end else begin
              cnt <= cnt - 6'd1;
            end
          end
          S_DIV: begin
            if (cnt == 6'(DIV_ITERS - 1)) state <= S_FIX;
            else                          cnt   <= cnt + 6'd1;
          end
          S_FIX: begin
            if (div_done) begin
              state   <= S_DONE;
              wr_q    <= 1'b1;
              hi_data <= fix_r;
              lo_data <= fix_q;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // A flush landing in the write cycle must still cancel the HI/LO capture.
  assign hi_write = wr_q & ~flush;
  assign lo_write = hi_write;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed checks of muldiv_unit: latencies, busy window, corner-case divides, flush and reset abort.
module tb_muldiv_unit;
  import mycpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi_in;
  logic [31:0] lo_in;
  logic        flush;
  logic        busy;
  logic        hi_write;
  logic        lo_write;
  logic [31:0] hi_data;
  logic [31:0] lo_data;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.MUL_CYCLES(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .hi_in    (hi_in),
    .lo_in    (lo_in),
    .flush    (flush),
    .busy     (busy),
    .hi_write (hi_write),
    .lo_write (lo_write),
    .hi_data  (hi_data),
    .lo_data  (lo_data)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge (cycle 0); returns at the negedge of cycle 1.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
    a     = 32'h0;
    b     = 32'h0;
  endtask

  // Returns at the negedge of the write cycle so a follow-on op can be accepted there.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input int lat,
                        input logic [31:0] eh, input logic [31:0] el);
    int cyc   = 1;
    int nbusy = 0;
    issue(o, x, y);
    while (hi_write !== 1'b1 && cyc < 80) begin
      if (busy === 1'b1) nbusy++;
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_lat"},   64'(cyc), 64'(lat));
    chk({tag, "_busyn"}, 64'(nbusy), 64'(lat - 1));
    chk({tag, "_busy0"}, 64'(busy), 64'd0);
    chk({tag, "_lowr"},  64'(lo_write), 64'd1);
    chk({tag, "_data"},  {hi_data, lo_data}, {eh, el});
  endtask

  initial begin
    int nwr;
    reset = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    op    = OP_MULT;
    a     = 32'h0;
    b     = 32'h0;
    hi_in = 32'h0;
    lo_in = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_wr",   64'(hi_write), 64'd0);
    chk("rst_data", {hi_data, lo_data}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op("mult", OP_MULT, 32'hFFFF_FFFF, 32'd2, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    @(negedge clk);
    chk("mult_pulse_end", 64'(hi_write), 64'd0);
    chk("mult_hold", {hi_data, lo_data}, 64'hFFFF_FFFF_FFFF_FFFE);

    @(negedge clk);
    run_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 2, 32'h0000_0001, 32'hFFFF_FFFE);
    @(negedge clk);
    run_op("mult_negneg", OP_MULT, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 2, 32'h0, 32'd15);
    @(negedge clk);
    run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    @(negedge clk);
    run_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 34, 32'd1, 32'hFFFF_FFFD);
    @(negedge clk);
    run_op("divu_100_3", OP_DIVU, 32'd100, 32'd3, 34, 32'd1, 32'd33);
    @(negedge clk);
    run_op("divu_by0", OP_DIVU, 32'd7, 32'd0, 34, 32'd7, 32'hFFFF_FFFF);
    @(negedge clk);
    run_op("div_by0", OP_DIV, 32'hFFFF_FFF9, 32'd0, 34, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    @(negedge clk);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h0, 32'h8000_0000);
    run_op("b2b_multu", OP_MULTU, 32'd3, 32'd4, 2, 32'h0, 32'hC);

    // Flush at cycle 10 of a divide.
    @(negedge clk);
    issue(OP_DIVU, 32'd100, 32'd3);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    nwr = 0;
    for (int i = 0; i < 40; i++) begin
      if (hi_write === 1'b1) nwr++;
      @(negedge clk);
    end
    chk("flush_nowr", 64'(nwr), 64'd0);

    // Start and flush together: nothing accepted.
    start = 1'b1;
    flush = 1'b1;
    op    = OP_MULTU;
    a     = 32'd5;
    b     = 32'd5;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    chk("sflush_busy", 64'(busy), 64'd0);
    @(negedge clk);
    chk("sflush_nowr", 64'(hi_write), 64'd0);

    // Flush during the write cycle itself.
    @(negedge clk);
    issue(OP_MULT, 32'd6, 32'd7);
    @(negedge clk);
    flush = 1'b1;
    #1;
    chk("wflush_wr", 64'(hi_write), 64'd0);
    chk("wflush_lowr", 64'(lo_write), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    chk("wflush_busy", 64'(busy), 64'd0);
    chk("wflush_after", 64'(hi_write), 64'd0);

    // Reset during a divide clears state and data.
    @(negedge clk);
    issue(OP_DIV, 32'd1000, 32'd7);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_data", {hi_data, lo_data}, 64'd0);
    nwr = 0;
    for (int i = 0; i < 40; i++) begin
      if (hi_write === 1'b1) nwr++;
      @(negedge clk);
    end
    chk("mrst_nowr", 64'(nwr), 64'd0);

`ifdef MULDIV_MADD_EN
    hi_in = 32'h0;
    lo_in = 32'hFFFF_FFFF;
    run_op("maddu", OP_MADDU, 32'd1, 32'd1, 3, 32'd1, 32'd0);
    @(negedge clk);
    hi_in = 32'h0;
    lo_in = 32'd5;
    run_op("msub", OP_MSUB, 32'd2, 32'd3, 3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(negedge clk);
    hi_in = 32'h0000_0001;
    lo_in = 32'h0;
    run_op("madd_neg", OP_MADD, 32'hFFFF_FFFF, 32'd1, 3, 32'h0, 32'hFFFF_FFFF);
`else
    hi_in = 32'h0;
    lo_in = 32'hFFFF_FFFF;
    @(negedge clk);
    issue(OP_MADDU, 32'd1, 32'd1);
    nwr = 0;
    for (int i = 0; i < 6; i++) begin
      chk("madd_off_busy", 64'(busy), 64'd0);
      if (hi_write === 1'b1) nwr++;
      @(negedge clk);
    end
    chk("madd_off_nowr", 64'(nwr), 64'd0);
    run_op("after_madd_off", OP_MULTU, 32'd9, 32'd9, 2, 32'h0, 32'd81);
`endif

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
